// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single memory port shared by I-cache and D-cache
// Optional macro: ARB_FAIRNESS_EN (bounded D priority so I cannot starve)
module mem_bus_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_write;
  logic              last_d;
  logic              first_cyc;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              done;
  logic              d_req;
  logic              fair_i;

  assign d_req = D_READ | D_WRITE;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign fair_i = I_READ && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Never exceeds STARVE_LIMIT: at the limit with I waiting, I is granted and the count clears.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_nxt == GRANT_I) begin
      starve_cnt <= '0;
    end else if (state == IDLE && state_nxt == GRANT_D && I_READ) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Fixed D priority; the limit is only meaningful when fairness is built in.
  assign fair_i = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fair_i)      state_nxt = GRANT_I;
        else if (d_req)  state_nxt = GRANT_D;
        else if (I_READ) state_nxt = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (!first_cyc && !MEM_BUSYWAIT) begin
          done      = 1'b1;
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      last_d    <= 1'b0;
      first_cyc <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      first_cyc <= 1'b0;
      if (state == IDLE && state_nxt == GRANT_D) begin
        lat_addr  <= D_ADDRESS;
        lat_wdata <= D_WRITEDATA;
        lat_write <= D_WRITE;
        last_d    <= 1'b1;
        first_cyc <= 1'b1;
      end else if (state == IDLE && state_nxt == GRANT_I) begin
        lat_addr  <= I_ADDRESS;
        lat_write <= 1'b0;
        last_d    <= 1'b0;
        first_cyc <= 1'b1;
      end
      // Data is captured even if the requester dropped its request mid-grant.
      if (done && !lat_write) begin
        if (last_d) d_rdata <= MEM_READDATA;
        else        i_rdata <= MEM_READDATA;
      end
    end
  end

  assign MEM_READ      = (state == GRANT_I || state == GRANT_D) && !lat_write;
  assign MEM_WRITE     = (state == GRANT_I || state == GRANT_D) && lat_write;
  assign MEM_ADDRESS   = lat_addr;
  assign MEM_WRITEDATA = lat_wdata;
  assign I_READDATA    = i_rdata;
  assign D_READDATA    = d_rdata;

  // RESET gating keeps the stalls low combinationally while reset is asserted.
  assign I_BUSYWAIT = RESET & I_READ & ~(state == RELEASE && !last_d);
  assign D_BUSYWAIT = RESET & d_req  & ~(state == RELEASE && last_d);

endmodule
